// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg
//   Shared definitions for the bit-serial subtractor:
//     - state_e : FSM state encoding (IDLE=0, SHIFT=1, DONE=2)
//     - clog2   : ceil(log2(n)), used to size the bit counter as clog2(WIDTH+1)
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Constant function; evaluated at elaboration only.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// full_subtractor
//   Combinational 1-bit full subtractor: d = x - y - bin.
//   Ports:
//     x    in  minuend bit
//     y    in  subtrahend bit
//     bin  in  borrow in
//     d    out difference bit
//     bout out borrow out
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  // Borrow when y exceeds x, or when they match and a borrow is pending.
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor, diff = a - b, LSB first, one bit per clock,
//   built around a single full_subtractor cell and a registered borrow.
//   Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
//   Ports:
//     clk    in   clock, rising edge
//     rst    in   asynchronous active-high reset
//     start  in   request, sampled only while ready
//     a, b   in   operands, captured on accepted start
//     ready  out  1 in IDLE and DONE
//     busy   out  1 in SHIFT
//     done   out  one-cycle pulse, diff/borrow valid
//     diff   out  a - b mod 2^WIDTH, held until the next result
//     borrow out  1 iff a < b (unsigned), held with diff
//     ovf    out  (SERIAL_SUB_OVF_EN only) signed overflow of a - b
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int              CW   = clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  // Holds the first WIDTH-1 result bits; the last bit goes straight to diff.
  logic [WIDTH-2:0]   res_q, res_d;
  logic               bin_q, bin_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               borrow_q, borrow_d;

  logic               fs_d, fs_bout;
  logic [WIDTH-1:0]   res_ext;

`ifdef SERIAL_SUB_OVF_EN
  logic               amsb_q, amsb_d;
  logic               bmsb_q, bmsb_d;
  logic               ovf_q, ovf_d;
`endif

  full_subtractor u_fs (
    .x    (a_q[0]),
    .y    (b_q[0]),
    .bin  (bin_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  // New bit enters at the MSB; shifting the extended vector right by one
  // gives the next partial result, and on the last step the full diff.
  assign res_ext = {fs_d, res_q};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    amsb_d   = amsb_q;
    bmsb_d   = bmsb_q;
    ovf_d    = ovf_q;
`endif

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d = ST_SHIFT;
          a_d     = a;
          b_d     = b;
          bin_d   = 1'b0;
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
          amsb_d  = a[WIDTH-1];
          bmsb_d  = b[WIDTH-1];
`endif
        end
      end

      ST_SHIFT: begin
        res_d = res_ext[WIDTH-1:1];
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        bin_d = fs_bout;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d  = ST_DONE;
          diff_d   = res_ext;
          borrow_d = fs_bout;
`ifdef SERIAL_SUB_OVF_EN
          // fs_d is the result MSB on the final step.
          ovf_d    = (amsb_q != bmsb_q) & (fs_d != amsb_q);
`endif
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      bin_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      amsb_q   <= 1'b0;
      bmsb_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
      amsb_q   <= amsb_d;
      bmsb_q   <= bmsb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy   = (state_q == ST_SHIFT);
  assign done   = (state_q == ST_DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Scoreboard bench for serial_subtractor (WIDTH=8). Expected results are
//   queued when an operation is launched and compared when done pulses.
//   Build with SERIAL_SUB_OVF_EN to also cover the ovf output.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] d;
    logic         br;
    logic         ov;
  } exp_t;

  logic         clk, rst, start;
  logic [W-1:0] a, b;
  logic         ready, busy, done, borrow;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Result check on every done pulse.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("diff", 32'(diff), 32'(mon_e.d));
        chk("borrow", 32'(borrow), 32'(mon_e.br));
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf", 32'(ovf), 32'(mon_e.ov));
`endif
      end
    end
  end

  // Launch one op (accepted from IDLE or DONE), then wait for done and check
  // latency. With glitch set, pulse start with other operands mid-SHIFT.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit glitch);
    exp_t e;
    int   k;
    int   lat;
    k = 0;
    while (ready !== 1'b1 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    if (ready !== 1'b1) chk("ready_wait", 32'd0, 32'd1);
    e.d  = W'(av - bv);
    e.br = (av < bv);
    e.ov = (av[W-1] != bv[W-1]) && (e.d[W-1] != av[W-1]);
    start = 1'b1;
    a = av;
    b = bv;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    chk("busy_after_accept", 32'(busy), 32'd1);
    lat = 0;
    for (int c = 1; c <= 2 * W; c++) begin
      @(posedge clk); #1;
      if (glitch && c == 2) begin
        start = 1'b1;
        a = 8'h10;
        b = 8'h01;
      end else if (glitch && c == 3) begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        lat = c;
        break;
      end
    end
    chk("latency", 32'(lat), 32'(W));
    chk("ready_in_done", 32'(ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(8'h05, 8'h03, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_diff", 32'(diff), 32'h02);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);

    // Back-to-back: each call starts while the previous op sits in DONE.
    do_op(8'h03, 8'h05, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b0);
    do_op(8'h00, 8'hFF, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    // Start pulse while busy must not disturb the running op.
    do_op(8'h05, 8'h03, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("glitch_hold", 32'(diff), 32'h02);

    // Reset four cycles into SHIFT; outputs must clear without a clock edge.
    start = 1'b1;
    a = 8'h55;
    b = 8'h11;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_abort_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_borrow", 32'(borrow), 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_op(8'h20, 8'h10, 1'b0);

    repeat (8) do_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1'b0);
    do_op(8'h80, 8'h01, 1'b0);
    do_op(8'h7F, 8'hFF, 1'b0);
    do_op(8'h05, 8'h03, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
